// File: rtl/multimode_counter_pkg.sv
// Shared constants for the multimode counter.
//   MODE_* : encodings of the 2-bit mode input.
//   DIR_*  : encodings of the direction bit.
package multimode_counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_UPDOWN = 2'd2;
  localparam logic [1:0] MODE_TRI    = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/multimode_counter_if.sv
// Control/status bundle of the multimode counter.
//   master : drives en/clr/load/load_val/max_val/mode/dir_in, observes count/dir/tc.
//   slave  : the counter side.
interface multimode_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] max_val;
  logic [1:0]       mode;
  logic             dir_in;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;

  modport master (
    output en, clr, load, load_val, max_val, mode, dir_in,
    input  count, dir, tc
  );

  modport slave (
    input  en, clr, load, load_val, max_val, mode, dir_in,
    output count, dir, tc
  );
endinterface

// File: rtl/counter_next_state.sv
// Combinational step function of the multimode counter.
//   count_i/dir_i    : current registered state.
//   mode_i, dir_in_i : mode and UPDOWN direction request.
//   max_val_i        : inclusive upper bound.
//   count_o/dir_o/tc_o : state after one enabled step.
module counter_next_state
  import multimode_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_in_i,
  input  logic [WIDTH-1:0] max_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             dir_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] up_count, down_count;
  logic             up_tc, down_tc;

  // Up step: wrap to zero once the bound is reached or exceeded.
  always_comb begin
    up_count = count_i + WIDTH'(1);
    up_tc    = 1'b0;
    if (count_i >= max_val_i) begin
      up_count = '0;
      up_tc    = 1'b1;
    end
  end

  // Down step: an out-of-range count (bound lowered live) clamps silently.
  always_comb begin
    down_count = count_i - WIDTH'(1);
    down_tc    = 1'b0;
    if (count_i > max_val_i) begin
      down_count = max_val_i;
    end else if (count_i == '0) begin
      down_count = max_val_i;
      down_tc    = 1'b1;
    end
  end

  always_comb begin
    count_o = count_i;
    dir_o   = dir_i;
    tc_o    = 1'b0;
    if (max_val_i == '0) begin
      count_o = '0;
      tc_o    = 1'b1;
    end else begin
      unique case (mode_i)
        MODE_UP: begin
          dir_o   = DIR_UP;
          count_o = up_count;
          tc_o    = up_tc;
        end
        MODE_DOWN: begin
          dir_o   = DIR_DOWN;
          count_o = down_count;
          tc_o    = down_tc;
        end
        MODE_UPDOWN: begin
          dir_o   = dir_in_i;
          count_o = (dir_in_i == DIR_UP) ? up_count : down_count;
          tc_o    = (dir_in_i == DIR_UP) ? up_tc : down_tc;
        end
        MODE_TRI: begin
          if (dir_i == DIR_UP) begin
            if (count_i >= max_val_i) begin
              count_o = max_val_i - WIDTH'(1);
              dir_o   = DIR_DOWN;
              tc_o    = 1'b1;
            end else begin
              count_o = count_i + WIDTH'(1);
            end
          end else if (count_i == '0) begin
            count_o = WIDTH'(1);
            dir_o   = DIR_UP;
            tc_o    = 1'b1;
          end else begin
            // Same clamp as DOWN when the bound was lowered under the count.
            count_o = (count_i > max_val_i) ? max_val_i : count_i - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multimode_counter.sv
// Parametrised up/down/updown/triangle counter with clear, load, enable
// and a registered terminal-count pulse.
//   clk : rising-edge clock.   rst : asynchronous active-high reset.
//   bus : slave side of multimode_counter_if (controls in, count/dir/tc out).
module multimode_counter
  import multimode_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input logic                 clk,
  input logic                 rst,
  multimode_counter_if.slave  bus
);

  logic [WIDTH-1:0] count_q, count_d, step_count, load_count;
  logic             dir_q, dir_d, step_dir;
  logic             tc_q, tc_d, step_tc;

  counter_next_state #(
    .WIDTH (WIDTH)
  ) u_next (
    .count_i   (count_q),
    .dir_i     (dir_q),
    .mode_i    (bus.mode),
    .dir_in_i  (bus.dir_in),
    .max_val_i (bus.max_val),
    .count_o   (step_count),
    .dir_o     (step_dir),
    .tc_o      (step_tc)
  );

  assign load_count = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;

  // Priority: clr > load > en; tc is rewritten every edge.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (bus.load) begin
      count_d = load_count;
      // A triangle loaded at an end point must turn around on the next step.
      if (bus.mode == MODE_TRI) begin
        if (load_count == bus.max_val) begin
          dir_d = DIR_DOWN;
        end else if (load_count == '0) begin
          dir_d = DIR_UP;
        end
      end
    end else if (bus.en) begin
      count_d = step_count;
      dir_d   = step_dir;
      tc_d    = step_tc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_multimode_counter.sv
module tb_multimode_counter;
  import multimode_counter_pkg::*;

  localparam int unsigned WIDTH = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multimode_counter_if #(.WIDTH(WIDTH)) bus ();

  multimode_counter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [WIDTH-1:0] c, input logic d,
                           input logic t);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".dir"}, 32'(bus.dir), 32'(d));
    chk({tag, ".tc"}, 32'(bus.tc), 32'(t));
  endtask

  int up_c[6]  = '{1, 2, 3, 4, 0, 1};
  int up_t[6]  = '{0, 0, 0, 0, 1, 0};
  int tri_c[7] = '{1, 2, 3, 2, 1, 0, 1};
  int tri_d[7] = '{1, 1, 1, 0, 0, 0, 1};
  int tri_t[7] = '{0, 0, 0, 1, 0, 0, 1};
  int dn_c[4]  = '{1, 0, 5, 4};
  int dn_t[4]  = '{0, 0, 1, 0};
  int ud_c[8]  = '{1, 2, 3, 2, 1, 0, 7, 6};
  int ud_d[8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
  int ud_t[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.max_val = 3'd4; bus.mode = MODE_UP; bus.dir_in = 1'b1;
    #12;
    chk_state("reset", 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // UP, max 4: wraps every fifth edge.
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_state($sformatf("up%0d", i), 3'(up_c[i]), 1'b1, 1'(up_t[i]));
    end

    // TRIANGLE, max 3, from a cleared start.
    bus.clr = 1'b1;
    step();
    chk_state("tri_clr", 3'd0, 1'b1, 1'b0);
    bus.clr = 1'b0; bus.mode = MODE_TRI; bus.max_val = 3'd3;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_state($sformatf("tri%0d", i), 3'(tri_c[i]), 1'(tri_d[i]), 1'(tri_t[i]));
    end

    // DOWN, max 5, loaded with 2 (dir untouched by the load).
    bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 3'd2; bus.mode = MODE_DOWN;
    bus.max_val = 3'd5;
    step();
    chk_state("dn_load", 3'd2, 1'b1, 1'b0);
    bus.load = 1'b0; bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("dn%0d", i), 3'(dn_c[i]), 1'b0, 1'(dn_t[i]));
    end
    // Load above the bound clamps; load beats en.
    bus.load = 1'b1; bus.load_val = 3'd7; bus.max_val = 3'd4;
    step();
    chk_state("load_clamp", 3'd4, 1'b0, 1'b0);

    // UP at 6 with max 7, then bound lowered to 2 and then 0.
    bus.load_val = 3'd6; bus.max_val = 3'd7; bus.mode = MODE_UP;
    step();
    chk("up6.count", 32'(bus.count), 32'd6);
    bus.load = 1'b0; bus.max_val = 3'd2;
    step();
    chk_state("max_lowered", 3'd0, 1'b1, 1'b1);
    bus.max_val = 3'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_state($sformatf("max0_%0d", i), 3'd0, 1'b1, 1'b1);
    end

    // UPDOWN, max 7: three up, five down.
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0; bus.mode = MODE_UPDOWN; bus.max_val = 3'd7;
    for (int i = 0; i < 8; i++) begin
      bus.dir_in = (i < 3) ? 1'b1 : 1'b0;
      step();
      chk_state($sformatf("ud%0d", i), 3'(ud_c[i]), 1'(ud_d[i]), 1'(ud_t[i]));
    end
    bus.en = 1'b0; bus.dir_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("hold%0d", i), 3'd6, 1'b0, 1'b0);
    end
    // clr wins over load.
    bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 3'd5;
    step();
    chk_state("clr_vs_load", 3'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    bus.clr = 1'b0; bus.load = 1'b1; bus.load_val = 3'd3; bus.mode = MODE_UP;
    step();
    chk("pre_rst.count", 32'(bus.count), 32'd3);
    bus.load = 1'b0; bus.en = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk_state("async_rst", 3'd0, 1'b1, 1'b0);
    #2 rst = 1'b0;
    step();
    chk_state("post_rst", 3'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
